// File: rtl/hwpe_ctrl_reqrsp_mux_pkg.sv
// Shared constants and the request payload type for the HWPE reqrsp control path.
package hwpe_ctrl_package;

  localparam int unsigned HWPE_CTRL_REQRSP_MAX_INIT = 8;
  localparam int unsigned HWPE_CTRL_REQRSP_AW       = 32;
  localparam int unsigned HWPE_CTRL_REQRSP_DW       = 64;

  typedef struct packed {
    logic [HWPE_CTRL_REQRSP_AW-1:0]   addr;
    logic                             write;
    logic [HWPE_CTRL_REQRSP_DW-1:0]   data;
    logic [HWPE_CTRL_REQRSP_DW/8-1:0] strb;
  } hwpe_ctrl_reqrsp_req_t;

endpackage

// File: rtl/hwpe_ctrl_reqrsp_id_fifo.sv
// Synchronous FIFO holding the source initiator index of each accepted request.
module hwpe_ctrl_reqrsp_id_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned W     = 1,
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/hwpe_ctrl_reqrsp_mux.sv
// N-to-1 reqrsp multiplexer: round-robin on q with grant lock under backpressure,
// in-order p routing through an ID FIFO, sticky error on orphan responses.
module hwpe_ctrl_reqrsp_mux
  import hwpe_ctrl_package::*;
#(
  parameter  int unsigned N_INIT          = 2,
  parameter  int unsigned AW              = HWPE_CTRL_REQRSP_AW,
  parameter  int unsigned DW              = HWPE_CTRL_REQRSP_DW,
  parameter  int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned IW              = $clog2(N_INIT),
  localparam int unsigned CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_INIT*AW-1:0]     in_q_addr_i,
  input  logic [N_INIT-1:0]        in_q_write_i,
  input  logic [N_INIT*DW-1:0]     in_q_data_i,
  input  logic [N_INIT*(DW/8)-1:0] in_q_strb_i,
  input  logic [N_INIT-1:0]        in_q_valid_i,
  output logic [N_INIT-1:0]        in_q_ready_o,
  output logic [N_INIT*DW-1:0]     in_p_data_o,
  output logic [N_INIT-1:0]        in_p_valid_o,
  input  logic [N_INIT-1:0]        in_p_ready_i,
  output logic [AW-1:0]            out_q_addr_o,
  output logic                     out_q_write_o,
  output logic [DW-1:0]            out_q_data_o,
  output logic [DW/8-1:0]          out_q_strb_o,
  output logic                     out_q_valid_o,
  input  logic                     out_q_ready_i,
  input  logic [DW-1:0]            out_p_data_i,
  input  logic                     out_p_valid_i,
  output logic                     out_p_ready_o,
  output logic [CW-1:0]            outstanding_o,
  output logic                     err_o
);

  if (N_INIT < 2 || N_INIT > HWPE_CTRL_REQRSP_MAX_INIT) begin : g_bad_n_init
    $error("hwpe_ctrl_reqrsp_mux: N_INIT out of range");
  end

  logic [IW-1:0] rr_q, rr_d, lock_idx_q, grant, cand, head;
  logic          lock_q, found, err_q;
  logic          fifo_full, fifo_empty, q_ok, q_hs, p_hs;

  always_comb begin
    grant = rr_q;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_INIT; k++) begin
      cand = IW'((32'(rr_q) + k) % N_INIT);
      if (!found && in_q_valid_i[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
    if (lock_q) grant = lock_idx_q;
  end

  // Full gating deliberately ignores a same-cycle pop to keep p off the q timing path.
  assign q_ok          = !rst_i && !fifo_full;
  assign out_q_valid_o = q_ok && (|in_q_valid_i);
  assign q_hs          = out_q_valid_o && out_q_ready_i;
  assign rr_d          = (grant == IW'(N_INIT - 1)) ? '0 : grant + IW'(1);

  assign out_q_addr_o  = in_q_addr_i[grant*AW +: AW];
  assign out_q_write_o = in_q_write_i[grant];
  assign out_q_data_o  = in_q_data_i[grant*DW +: DW];
  assign out_q_strb_o  = in_q_strb_i[grant*(DW/8) +: DW/8];

  always_comb begin
    in_q_ready_o        = '0;
    in_q_ready_o[grant] = q_ok && out_q_ready_i;
  end

  always_comb begin
    in_p_valid_o       = '0;
    in_p_valid_o[head] = !rst_i && !fifo_empty && out_p_valid_i;
  end

  // An empty FIFO means nobody owns the response, so it is accepted and dropped.
  assign out_p_ready_o = !rst_i && (fifo_empty || in_p_ready_i[head]);
  assign p_hs          = !rst_i && !fifo_empty && out_p_valid_i && in_p_ready_i[head];
  assign in_p_data_o   = {N_INIT{out_p_data_i}};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (q_hs) begin
        rr_q   <= rr_d;
        lock_q <= 1'b0;
      end else if (out_q_valid_o) begin
        lock_q     <= 1'b1;
        lock_idx_q <= grant;
      end
      if (fifo_empty && out_p_valid_i) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  hwpe_ctrl_reqrsp_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (IW)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (q_hs),
    .pop_i   (p_hs),
    .data_i  (grant),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

endmodule

// File: tb/tb_hwpe_ctrl_reqrsp_mux.sv
// Directed bench for hwpe_ctrl_reqrsp_mux with N_INIT=2, AW=32, DW=64, MAX_OUTSTANDING=4.
module tb_hwpe_ctrl_reqrsp_mux;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [63:0]  in_q_addr_i;
  logic [1:0]   in_q_write_i;
  logic [127:0] in_q_data_i;
  logic [15:0]  in_q_strb_i;
  logic [1:0]   in_q_valid_i;
  logic [1:0]   in_q_ready_o;
  logic [127:0] in_p_data_o;
  logic [1:0]   in_p_valid_o;
  logic [1:0]   in_p_ready_i;
  logic [31:0]  out_q_addr_o;
  logic         out_q_write_o;
  logic [63:0]  out_q_data_o;
  logic [7:0]   out_q_strb_o;
  logic         out_q_valid_o;
  logic         out_q_ready_i;
  logic [63:0]  out_p_data_i;
  logic         out_p_valid_i;
  logic         out_p_ready_o;
  logic [2:0]   outstanding_o;
  logic         err_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  hwpe_ctrl_reqrsp_mux #(
    .N_INIT          (2),
    .AW              (32),
    .DW              (64),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .in_q_addr_i   (in_q_addr_i),
    .in_q_write_i  (in_q_write_i),
    .in_q_data_i   (in_q_data_i),
    .in_q_strb_i   (in_q_strb_i),
    .in_q_valid_i  (in_q_valid_i),
    .in_q_ready_o  (in_q_ready_o),
    .in_p_data_o   (in_p_data_o),
    .in_p_valid_o  (in_p_valid_o),
    .in_p_ready_i  (in_p_ready_i),
    .out_q_addr_o  (out_q_addr_o),
    .out_q_write_o (out_q_write_o),
    .out_q_data_o  (out_q_data_o),
    .out_q_strb_o  (out_q_strb_o),
    .out_q_valid_o (out_q_valid_o),
    .out_q_ready_i (out_q_ready_i),
    .out_p_data_i  (out_p_data_i),
    .out_p_valid_i (out_p_valid_i),
    .out_p_ready_o (out_p_ready_o),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic w, input logic [63:0] d);
    in_q_addr_i[i*32 +: 32] = a;
    in_q_write_i[i]         = w;
    in_q_data_i[i*64 +: 64] = d;
    in_q_strb_i[i*8 +: 8]   = 8'hFF;
  endtask

  // Inputs change just after a falling edge; checks run 1 time unit later, before the rising edge.
  task automatic settle;
    #1;
  endtask

  task automatic next_cycle;
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1;
    in_q_addr_i = '0; in_q_write_i = '0; in_q_data_i = '0; in_q_strb_i = '0;
    in_q_valid_i = 2'b11; in_p_ready_i = 2'b11; out_q_ready_i = 1'b1;
    out_p_data_i = 64'h0; out_p_valid_i = 1'b1;
    next_cycle;
    next_cycle;

    // Reset: all handshake outputs held low even with activity on the inputs.
    settle;
    chk("rst_in_q_ready", in_q_ready_o, 2'b00);
    chk("rst_out_q_valid", out_q_valid_o, 1'b0);
    chk("rst_out_p_ready", out_p_ready_o, 1'b0);
    chk("rst_in_p_valid", in_p_valid_o, 2'b00);
    chk("rst_outstanding", outstanding_o, 3'd0);
    chk("rst_err", err_o, 1'b0);
    next_cycle;

    // Single initiator write.
    rst_i = 1'b0; in_q_valid_i = 2'b01; out_p_valid_i = 1'b0;
    set_req(0, 32'h10, 1'b1, 64'h12345678_9ABCDEF0);
    set_req(1, 32'h99, 1'b0, 64'h1111);
    settle;
    chk("t1_out_q_valid", out_q_valid_o, 1'b1);
    chk("t1_out_q_addr", out_q_addr_o, 32'h10);
    chk("t1_out_q_write", out_q_write_o, 1'b1);
    chk("t1_out_q_data", out_q_data_o, 64'h12345678_9ABCDEF0);
    chk("t1_out_q_strb", out_q_strb_o, 8'hFF);
    chk("t1_in_q_ready", in_q_ready_o, 2'b01);
    chk("t1_err_after_rst", err_o, 1'b0);
    next_cycle;
    in_q_valid_i = 2'b00; out_p_valid_i = 1'b1; out_p_data_i = 64'hDEAD_BEEF;
    settle;
    chk("t1_outstanding1", outstanding_o, 3'd1);
    chk("t1_in_p_valid", in_p_valid_o, 2'b01);
    chk("t1_out_p_ready", out_p_ready_o, 1'b1);
    chk("t1_in_p_data", in_p_data_o, {2{64'hDEAD_BEEF}});
    next_cycle;
    out_p_valid_i = 1'b0;
    settle;
    chk("t1_outstanding0", outstanding_o, 3'd0);
    chk("t1_in_p_valid_idle", in_p_valid_o, 2'b00);
    chk("t1_err", err_o, 1'b0);
    next_cycle;

    // Brief reset so contention starts from rr=0.
    rst_i = 1'b1;
    next_cycle;
    rst_i = 1'b0;

    // Contention: grants alternate 0,1,0,1.
    set_req(0, 32'h100, 1'b0, 64'h0);
    set_req(1, 32'h200, 1'b0, 64'h0);
    in_q_valid_i = 2'b11;
    for (int c = 0; c < 4; c++) begin
      settle;
      chk("t2_addr", out_q_addr_o, (c % 2 == 0) ? 32'h100 : 32'h200);
      chk("t2_ready", in_q_ready_o, (c % 2 == 0) ? 2'b01 : 2'b10);
      next_cycle;
    end
    in_q_valid_i = 2'b00;
    out_p_valid_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      out_p_data_i = 64'(c);
      settle;
      chk("t2_rsp_route", in_p_valid_o, (c % 2 == 0) ? 2'b01 : 2'b10);
      next_cycle;
    end
    out_p_valid_i = 1'b0;
    settle;
    chk("t2_outstanding", outstanding_o, 3'd0);

    // Backpressure lock: init1 requests first, init0 joins while the target stalls.
    set_req(1, 32'h300, 1'b1, 64'h3);
    in_q_valid_i = 2'b10; out_q_ready_i = 1'b0;
    settle;
    chk("t3_c1_addr", out_q_addr_o, 32'h300);
    chk("t3_c1_valid", out_q_valid_o, 1'b1);
    chk("t3_c1_ready", in_q_ready_o, 2'b00);
    next_cycle;
    in_q_valid_i = 2'b11;
    settle;
    chk("t3_c2_addr", out_q_addr_o, 32'h300);
    next_cycle;
    settle;
    chk("t3_c3_addr", out_q_addr_o, 32'h300);
    next_cycle;
    out_q_ready_i = 1'b1;
    settle;
    chk("t3_c4_addr", out_q_addr_o, 32'h300);
    chk("t3_c4_ready", in_q_ready_o, 2'b10);
    next_cycle;
    in_q_valid_i = 2'b01;
    settle;
    chk("t3_c5_addr", out_q_addr_o, 32'h100);
    chk("t3_c5_ready", in_q_ready_o, 2'b01);
    next_cycle;
    in_q_valid_i = 2'b00; out_p_valid_i = 1'b1;
    settle;
    chk("t3_rsp0", in_p_valid_o, 2'b10);
    next_cycle;
    settle;
    chk("t3_rsp1", in_p_valid_o, 2'b01);
    next_cycle;
    out_p_valid_i = 1'b0;

    // Response backpressure: rr=1, so init1 then init0 are queued.
    set_req(1, 32'h400, 1'b0, 64'h0);
    set_req(0, 32'h500, 1'b0, 64'h0);
    in_q_valid_i = 2'b10;
    settle;
    chk("t5_push1", in_q_ready_o, 2'b10);
    next_cycle;
    in_q_valid_i = 2'b01;
    settle;
    chk("t5_push0", in_q_ready_o, 2'b01);
    next_cycle;
    in_q_valid_i = 2'b00; out_p_valid_i = 1'b1; in_p_ready_i = 2'b01;
    for (int c = 0; c < 2; c++) begin
      settle;
      chk("t5_stall_out_p_ready", out_p_ready_o, 1'b0);
      chk("t5_stall_in_p_valid", in_p_valid_o, 2'b10);
      chk("t5_stall_outstanding", outstanding_o, 3'd2);
      next_cycle;
    end
    in_p_ready_i = 2'b11;
    settle;
    chk("t5_rel_in_p_valid", in_p_valid_o, 2'b10);
    chk("t5_rel_out_p_ready", out_p_ready_o, 1'b1);
    next_cycle;
    settle;
    chk("t5_second_rsp", in_p_valid_o, 2'b01);
    next_cycle;
    out_p_valid_i = 1'b0;

    // FIFO full: four reads from init0, then a fifth is held off.
    set_req(0, 32'h600, 1'b0, 64'h0);
    in_q_valid_i = 2'b01;
    for (int c = 0; c < 4; c++) begin
      settle;
      chk("t4_fill_ready", in_q_ready_o, 2'b01);
      chk("t4_fill_outstanding", outstanding_o, 3'(c));
      next_cycle;
    end
    settle;
    chk("t4_full_ready", in_q_ready_o, 2'b00);
    chk("t4_full_valid", out_q_valid_o, 1'b0);
    chk("t4_full_outstanding", outstanding_o, 3'd4);
    next_cycle;
    out_p_valid_i = 1'b1;
    settle;
    chk("t4_pop_same_cycle_ready", in_q_ready_o, 2'b00);
    chk("t4_pop_in_p_valid", in_p_valid_o, 2'b01);
    next_cycle;
    out_p_valid_i = 1'b0;
    settle;
    chk("t4_after_pop_ready", in_q_ready_o, 2'b01);
    chk("t4_after_pop_valid", out_q_valid_o, 1'b1);
    chk("t4_after_pop_outstanding", outstanding_o, 3'd3);
    next_cycle;
    in_q_valid_i = 2'b00;
    settle;
    chk("t4_refull", outstanding_o, 3'd4);

    // Orphans: drain to 2 outstanding, reset, then two stale responses arrive.
    out_p_valid_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      settle;
      chk("t6_drain", in_p_valid_o, 2'b01);
      next_cycle;
    end
    out_p_valid_i = 1'b0;
    settle;
    chk("t6_pre_rst_outstanding", outstanding_o, 3'd2);
    next_cycle;
    rst_i = 1'b1;
    next_cycle;
    rst_i = 1'b0;
    settle;
    chk("t6_flushed", outstanding_o, 3'd0);
    chk("t6_err_clear", err_o, 1'b0);
    next_cycle;
    out_p_valid_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      settle;
      chk("t6_orphan_in_p_valid", in_p_valid_o, 2'b00);
      chk("t6_orphan_out_p_ready", out_p_ready_o, 1'b1);
      chk("t6_orphan_err", err_o, (c == 0) ? 1'b0 : 1'b1);
      next_cycle;
    end
    out_p_valid_i = 1'b0;
    settle;
    chk("t6_err_sticky", err_o, 1'b1);
    chk("t6_outstanding", outstanding_o, 3'd0);
    next_cycle;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hwpe_ctrl_reqrsp_mux.md
Name: hwpe_ctrl_reqrsp_mux

Overview:
- N-to-1 reqrsp multiplexer placed directly upstream of the HWPE reqrsp control target (the hwpe_ctrl_intf_reqrsp cfg slave).
- Lets several initiators (e.g. core, DMA, debug) share one control target.
- Round-robin arbitration on the request (q) channel.
- Responses (p) return in order, routed back to the originating initiator through an internal ID FIFO.

Parameters:
- N_INIT, 2, number of initiators (>=2).
- AW, 32, address width.
- DW, 64, data width; strobe width is DW/8.
- MAX_OUTSTANDING, 4, depth of the ID FIFO = maximum accepted-but-unanswered requests (power of 2, >=1).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- in_q_addr_i  in  N_INIT*AW  per-initiator request address.
- in_q_write_i  in  N_INIT  per-initiator write flag.
- in_q_data_i  in  N_INIT*DW  per-initiator write data.
- in_q_strb_i  in  N_INIT*DW/8  per-initiator byte strobes.
- in_q_valid_i  in  N_INIT  per-initiator request valid.
- in_q_ready_o  out  N_INIT  per-initiator request ready.
- in_p_data_o  out  N_INIT*DW  response data; broadcast to all initiators.
- in_p_valid_o  out  N_INIT  per-initiator response valid.
- in_p_ready_i  in  N_INIT  per-initiator response ready.
- out_q_addr_o / out_q_write_o / out_q_data_o / out_q_strb_o / out_q_valid_o  out  AW/1/DW/DW8/1  request to target.
- out_q_ready_i  in  1  target request ready.
- out_p_data_i  in  DW  target response data.
- out_p_valid_i  in  1  target response valid.
- out_p_ready_o  out  1  response ready to target.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current ID FIFO fill level.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- State:
  - rr_q: round-robin pointer, reset 0.
  - lock_q and lock_idx_q: grant hold, reset 0.
  - ID FIFO (source index per accepted request): reset empty.
  - err_q: reset 0.
- Reset outputs: while rst_i=1, all in_q_ready_o, in_p_valid_o, out_q_valid_o and out_p_ready_o are forced 0. outstanding_o=0, err_o=0.
- Request path latency: combinational, 0 cycles. Payload fields of the granted initiator are muxed to out_q_*.
- Grant selection:
  - If lock_q=1, grant = lock_idx_q.
  - Otherwise grant = first i with in_q_valid_i[i]=1, searching upward from rr_q with wrap-around.
- out_q_valid_o = (any valid) & !fifo_full.
- in_q_ready_o[grant] = out_q_ready_i & !fifo_full. All other in_q_ready_o bits are 0.
- Full gating: when the FIFO is full, the q path is blocked even if a pop happens in the same cycle. No combinational p->q path.
- Lock: if out_q_valid_o=1 and out_q_ready_i=0, then lock_q<=1 and lock_idx_q<=grant. Grant therefore stays stable until the handshake completes. Initiators must hold valid and payload stable until ready.
- On a q handshake (out_q_valid_o & out_q_ready_i):
  - push grant into the FIFO;
  - rr_q <= (grant+1) mod N_INIT;
  - lock_q <= 0.
- Response routing, FIFO non-empty, head = h:
  - in_p_valid_o[h] = out_p_valid_i; all other bits 0.
  - out_p_ready_o = in_p_ready_i[h].
  - in_p_data_o = out_p_data_i on all lanes.
- On a p handshake: pop the FIFO. Responses are strictly in order. Writes also receive one response each.
- Simultaneous push and pop: fill level unchanged. Pointers advance independently and wrap modulo MAX_OUTSTANDING.
- FIFO empty and out_p_valid_i=1: protocol error.
  - out_p_ready_o=1, so the orphan response is dropped.
  - No in_p_valid_o is asserted.
  - err_q<=1; stays set until reset.
- Reset mid-operation: the FIFO and lock are flushed. Responses to flushed requests that arrive later are handled as orphans: dropped, with err_o set.
- outstanding_o = FIFO fill level, registered, valid in the same cycle as the FIFO state.

Decomposition:
- hwpe_ctrl_package gets:
  - constant HWPE_CTRL_REQRSP_MAX_INIT = 8;
  - typedef of the per-initiator request payload struct (addr, write, data, strb), parameterised widths via the package defaults AW=32, DW=64.
- One sub-module: hwpe_ctrl_reqrsp_id_fifo.
  - Synchronous FIFO of $clog2(N_INIT)-bit entries, depth MAX_OUTSTANDING.
  - Ports: push, pop, data in/out, full, empty, count.
  - The arbiter and routing logic stay in the top module.

Test Plan:
- Single initiator write: init0 writes addr 0x10, data 0x12345678_9ABCDEF0, to a target with q_ready=1 and a response 1 cycle later -> out_q sees the same fields in the same cycle; in_p_valid_o[0] pulses; outstanding_o goes 1 then 0.
- Contention: init0 and init1 both valid every cycle, target always ready -> grants alternate 0,1,0,1 starting from rr=0; responses return to the matching initiator in order.
- Backpressure lock: init1 is requesting while out_q_ready_i=0 for 3 cycles, and init0 asserts valid in cycle 2 -> grant stays 1 and out_q_addr_o is stable; init1 is handshaken first, then init0.
- FIFO full: MAX_OUTSTANDING=4, 4 reads from init0 accepted, target withholds p_valid -> a 5th request sees in_q_ready_o=0 and outstanding_o=4; after one response pops, the 5th is accepted next cycle.
- Response backpressure: head=init1, in_p_ready_i[1]=0 for 2 cycles while in_p_ready_i[0]=1 -> out_p_ready_o=0 for those cycles; the FIFO is not popped; init0 receives no p_valid.
- Orphan/reset: assert rst_i with 2 outstanding, then the target returns 2 responses -> both dropped, err_o=1, no in_p_valid_o asserted.
